// File: rtl/vga_scanout.sv
// VGA pixel-side scanout: free-running 640x480 timing plus a valid/ready pixel
// sink that locks onto start-of-frame and recovers from underflow or misalignment.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        hsync,
  output logic        vsync,
  output logic        hactive,
  output logic        vactive,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        frame_start,
  output logic        underflow,
  input  logic        clr_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ALIGN, RUN, DRAIN} state_t;

  state_t          state, next_state;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic            visible, origin, frame_end;
  logic            take_pixel, set_err;

  assign visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign origin    = (hcnt == '0) && (vcnt == '0);
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

  // Raster position; runs in every state so sync never stalls.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) state <= ALIGN;
    else       state <= next_state;
  end

  // A misplaced sof is refused rather than consumed, so the source keeps it
  // at its head and the next ALIGN pass can lock onto it.
  always_comb begin
    next_state = state;
    pix_ready  = 1'b0;
    take_pixel = 1'b0;
    set_err    = 1'b0;
    case (state)
      ALIGN: begin
        pix_ready = !visible && !(pix_valid && pix_sof);
        if (frame_end && pix_valid && pix_sof) next_state = RUN;
      end
      RUN: begin
        if (visible) begin
          if (!pix_valid || (pix_sof && !origin)) begin
            set_err    = 1'b1;
            next_state = DRAIN;
          end else begin
            pix_ready  = 1'b1;
            take_pixel = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (frame_end) next_state = ALIGN;
      end
      default: next_state = ALIGN;
    endcase
  end

  // Every output is one cycle behind the raster counters; pixels are only
  // loaded in the visible window, which keeps blanking black.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hsync                <= 1'b1;
      vsync                <= 1'b1;
      hactive              <= 1'b0;
      vactive              <= 1'b0;
      {red, green, blue}   <= '0;
      frame_start          <= 1'b0;
      underflow            <= 1'b0;
    end else begin
      hsync                <= !((hcnt >= HS_ON) && (hcnt < HS_OFF));
      vsync                <= !((vcnt >= VS_ON) && (vcnt < VS_OFF));
      hactive              <= hcnt < H_VIS;
      vactive              <= vcnt < V_VIS;
      {red, green, blue}   <= take_pixel ? pix_data : 16'd0;
      frame_start          <= (state == RUN) && origin;
      if (set_err)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster (25x19) so whole frames
// run quickly; expected pixels are queued as the source stream is built.
module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int PF = HA * VA;
  localparam int NEVER = 32'h7fff_ffff;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        pix_ready, hsync, vsync, hactive, vactive, frame_start, underflow;
  logic [4:0]  red, blue;
  logic [5:0]  green;

  int tests = 0;
  int fails = 0;

  logic [16:0] srcQ[$];
  logic [15:0] expQ[$];
  int liveCount[4];
  int cyc, gapPos, clrPos, clrPos2, errP, clrP;
  bit lastAccept, countTiming;
  int hsLow, vsLow, hactHigh, vactHigh;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .pclk(pclk), .reset(reset), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .hsync(hsync), .vsync(vsync),
    .hactive(hactive), .vactive(vactive), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Source stream entries and the pixels the display is expected to show.
  task automatic pushSource(input int base, input int first, input int count);
    for (int i = first; i < first + count; i++)
      srcQ.push_back({(i == 0), 16'(base + i)});
  endtask

  task automatic pushExpect(input int base, input int count);
    for (int i = 0; i < count; i++) expQ.push_back(16'(base + i));
  endtask

  task automatic applyStimulus();
    pix_valid = (srcQ.size() > 0) && (cyc != gapPos);
    {pix_sof, pix_data} = (srcQ.size() > 0) ? srcQ[0] : 17'd0;
    clr_err = (cyc == clrPos) || (cyc == clrPos2);
  endtask

  // Compare the outputs that reflect raster position p against the reference.
  task automatic checkOutputs(input int p);
    int h, v, f, idx;
    logic [3:0] expT;
    logic [15:0] expRgb;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FT;
    expT = {!(h >= HA + HFP && h < HA + HFP + HS), !(v >= VA + VFP && v < VA + VFP + VS),
            (h < HA), (v < VA)};
    checkOutput("timing", {28'd0, hsync, vsync, hactive, vactive}, {28'd0, expT});
    if (countTiming) begin
      hsLow    += int'(!hsync);
      vsLow    += int'(!vsync);
      hactHigh += int'(hactive);
      vactHigh += int'(vactive);
    end
    idx = v * HA + h;
    expRgb = 16'd0;
    if (h < HA && v < VA && f < 4 && idx < liveCount[f])
      expRgb = (expQ.size() > 0) ? expQ.pop_front() : 16'hdead;
    checkOutput("rgb", {16'd0, red, green, blue}, {16'd0, expRgb});
    checkOutput("frame_start", 32'(frame_start),
                32'(h == 0 && v == 0 && f < 4 && liveCount[f] > 0));
    checkOutput("underflow", 32'(underflow), 32'(p >= errP && !(p >= clrP)));
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      #4 lastAccept = (pix_valid & pix_ready) === 1'b1;
      @(posedge pclk);
      cyc = reset ? 0 : cyc + 1;
      @(negedge pclk);
      if (cyc >= 1) checkOutputs(cyc - 1);
      if (lastAccept && srcQ.size() > 0) void'(srcQ.pop_front());
      applyStimulus();
    end
  endtask

  task automatic beginScenario();
    @(negedge pclk);
    reset = 1'b1;
    srcQ.delete();
    expQ.delete();
    gapPos = -1; clrPos = -1; clrPos2 = -1;
    errP = NEVER; clrP = NEVER;
    pix_valid = 1'b0; clr_err = 1'b0; lastAccept = 1'b0;
    for (int i = 0; i < 4; i++) liveCount[i] = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    cyc = 0;
  endtask

  task automatic releaseReset();
    reset = 1'b0;
    applyStimulus();
  endtask

  initial begin
    countTiming = 1'b0;
    hsLow = 0; vsLow = 0; hactHigh = 0; vactHigh = 0;

    // Two clean frames: first displayed frame is black, then both stream frames.
    beginScenario();
    pushSource(0, 0, PF);
    pushSource(1000, 0, PF);
    pushExpect(0, PF);
    pushExpect(1000, PF);
    liveCount[1] = PF;
    liveCount[2] = PF;
    countTiming = 1'b1;
    releaseReset();
    runCycles(3 * FT);
    countTiming = 1'b0;
    checkOutput("hsync_low_3f", 32'(hsLow), 32'(3 * VT * HS));
    checkOutput("vsync_low_3f", 32'(vsLow), 32'(3 * VS * HT));
    checkOutput("hactive_3f", 32'(hactHigh), 32'(3 * VT * HA));
    checkOutput("vactive_3f", 32'(vactHigh), 32'(3 * VA * HT));
    checkOutput("s1_drained", 32'(expQ.size()), 32'd0);

    // One-cycle valid gap at (5,3) of the first live frame, then reset mid-frame.
    beginScenario();
    pushSource(0, 0, PF);
    pushSource(2000, 0, PF);
    gapPos = FT + 3 * HT + 5;
    errP = gapPos;
    pushExpect(0, 3 * HA + 5);
    pushExpect(2000, PF);
    liveCount[1] = 3 * HA + 5;
    liveCount[3] = PF;
    releaseReset();
    runCycles(3 * FT + 8 * HT + 10);
    checkOutput("s2_pending", 32'(expQ.size()), 32'(PF - (8 * HA + 10)));
    reset = 1'b1;
    #4;
    @(posedge pclk);
    @(negedge pclk);
    checkOutput("rst_hsync", 32'(hsync), 32'd1);
    checkOutput("rst_vsync", 32'(vsync), 32'd1);
    checkOutput("rst_active", {30'd0, hactive, vactive}, 32'd0);
    checkOutput("rst_rgb", {16'd0, red, green, blue}, 32'd0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'd0);

    // Early sof at (7,2): the source restarts its frame there; clr_err
    // coincides with the error, a later clr_err clears it.
    beginScenario();
    pushSource(0, 0, 2 * HA + 7);
    pushSource(3000, 0, PF);
    errP = FT + 2 * HT + 7;
    clrPos = errP;
    clrPos2 = 2 * FT + 100;
    clrP = clrPos2;
    pushExpect(0, 2 * HA + 7);
    pushExpect(3000, PF);
    liveCount[1] = 2 * HA + 7;
    liveCount[3] = PF;
    releaseReset();
    runCycles(4 * FT);
    checkOutput("s3_drained", 32'(expQ.size()), 32'd0);

    // 37 stale non-sof pixels ahead of the frame must all be dropped.
    beginScenario();
    for (int i = 0; i < 37; i++) srcQ.push_back({1'b0, 16'(16'ha000 + i)});
    pushSource(4000, 0, PF);
    pushExpect(4000, PF);
    liveCount[1] = PF;
    releaseReset();
    runCycles(2 * FT);
    checkOutput("s4_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Pixel-side source of the VGA interface: generates 640x480 timing (hsync, vsync, hactive, vactive) and drives 5-6-5 RGB from a valid/ready pixel stream.
- Sits between the frame fetch logic, which pushes pixels with a start-of-frame marker, and the board VGA pins.
- The simulation PPM capture reads exactly these outputs.
- Contains frame-alignment and underflow recovery so a late or misaligned pixel source never tears the picture permanently.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pclk cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- pclk  in  1  pixel clock; sole clock
- reset  in  1  synchronous, active-high
- pix_data  in  16  pixel {r[4:0],g[5:0],b[4:0]}
- pix_sof  in  1  marks first pixel of a frame
- pix_valid  in  1  pixel stream valid
- pix_ready  out  1  pixel accepted when valid&ready
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- hactive  out  1  current output pixel is in visible columns
- vactive  out  1  current output pixel is in visible lines
- red  out  5  red
- green  out  6  green
- blue  out  5  blue
- frame_start  out  1  one-cycle pulse with first visible pixel
- underflow  out  1  sticky error flag
- clr_err  in  1  clears underflow

Behaviour:
- Counters: hcnt 0..H_TOTAL-1 with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). vcnt 0..V_TOTAL-1 with V_TOTAL=525.
  - vcnt increments when hcnt wraps.
  - Visible region is hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - hsync low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync analogous on vcnt.
- Pipeline: counters at cycle N. All outputs registered and reflect counter position N at cycle N+1. A pixel accepted at N appears on red/green/blue at N+1, aligned with hactive&vactive.
- Reset: hcnt=vcnt=0, state=ALIGN. Outputs: hsync=1, vsync=1, hactive=0, vactive=0, rgb=0, frame_start=0, underflow=0, pix_ready=0.
- RGB is forced to 0 whenever the registered hactive&vactive is 0.
- State machine:
  - ALIGN
    - Outside the visible region: pix_ready=1 while the head pixel lacks sof, so non-sof pixels are discarded.
    - Head pixel with pix_valid&pix_sof: pix_ready=0, hold it.
    - Go to RUN when hcnt=V_TOTAL-1 line's last cycle, i.e. hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, with an sof pixel held.
    - Otherwise output black for the whole frame.
  - RUN
    - pix_ready = visible(hcnt,vcnt).
    - Accepted pixel with pix_sof=1 anywhere except (0,0) is a misalignment: set underflow, go to DRAIN.
    - Visible position with pix_valid=0: output black for that pixel, set underflow, go to DRAIN.
    - frame_start pulses on output at (0,0) only in RUN.
  - DRAIN
    - pix_ready=0, black output until end of frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1), then go to ALIGN.
- Timing generation (sync, active flags) never stops, in any state.
- underflow is set as above and stays set until clr_err=1. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: the full reset state above is restored on the next edge; no partial line is completed.

Test Plan:
- Reset, then feed a continuous frame of pixels = {pixel index}[15:0] with sof on the first:
  - first frame black.
  - frame_start pulses on the following frame.
  - pixel (0,0) outputs red=0, green=0, blue=0.
  - pixel (1,0) outputs blue=1.
  - underflow stays 0.
- Timing check, 3 frames:
  - hsync low exactly 96 cycles per 800.
  - vsync low exactly 2 lines (1600 cycles) per 525 lines.
  - hactive high 640 cycles per line.
  - vactive high 480 lines.
- Deassert pix_valid for 1 cycle at pixel (100,5):
  - that pixel and the rest of the frame are black.
  - underflow=1.
  - the block realigns on the next sof and outputs a correct frame after.
- Insert sof at pixel (20,3) mid-frame: underflow=1, DRAIN, realign on that sof held through blanking.
- Source presents 37 non-sof pixels before sof while in ALIGN: all 37 consumed and dropped; the output frame starts with the sof pixel.
- clr_err pulse clears underflow. clr_err coinciding with a new underflow leaves underflow=1. reset asserted at (300,200) returns all outputs to reset values the next cycle.
